// File: rtl/diff_frame_ctrl.sv
// Differential (relative-code) dibit decoder with frame sync acquisition,
// flywheel tolerance of missed sync words and 180-degree ambiguity removal.
module diff_frame_ctrl #(
  parameter logic [15:0] SYNC_WORD = 16'h1ACF,
  parameter int          FRAME_LEN = 64,
  parameter int          MISS_MAX  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] cd,
  output logic [1:0] ab,
  output logic       ab_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       locked,
  output logic       inv
);

  // cnt also counts the 8 sync dibits in CHECK, so it never shrinks below 3 bits.
  localparam int CW = ($clog2(FRAME_LEN) > 3) ? $clog2(FRAME_LEN) : 3;

  localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(7);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    MISS_LIM  = 4'(MISS_MAX);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    cd_prev;
  logic [15:0]   sr;
  logic [CW-1:0] cnt;
  logic [3:0]    miss;

  logic [1:0]  d;
  logic [15:0] w;
  logic        match_pos;
  logic        match_neg;
  logic [3:0]  miss_inc;

  assign d         = cd ^ cd_prev;
  assign w         = {sr[13:0], d};
  assign match_pos = (w == SYNC_WORD);
  assign match_neg = (w == ~SYNC_WORD);
  assign miss_inc  = miss + 4'd1;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the pre-edge values of state, cnt, miss and inv.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      cd_prev     <= 2'b00;
      sr          <= '0;
      cnt         <= '0;
      miss        <= '0;
      ab          <= 2'b00;
      ab_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      locked      <= 1'b0;
      inv         <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle; ab itself holds across idle cycles.
      ab_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      if (sym_valid) begin
        cd_prev <= cd;
        sr      <= w;
        case (state)
          HUNT: begin
            if (match_pos || match_neg) begin
              state  <= PAYLOAD;
              inv    <= match_neg;
              locked <= 1'b1;
              cnt    <= '0;
              miss   <= '0;
            end
          end
          PAYLOAD: begin
            ab          <= d ^ {inv, inv};
            ab_valid    <= 1'b1;
            frame_start <= (cnt == '0);
            frame_end   <= (cnt == LAST_CNT);
            if (cnt == LAST_CNT) begin
              state <= CHECK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          CHECK: begin
            if (cnt == SYNC_LAST) begin
              cnt <= '0;
              if (match_pos || match_neg) begin
                state <= PAYLOAD;
                miss  <= '0;
                inv   <= match_neg;
              end else begin
                miss <= miss_inc;
                // Flywheel through the frame unless the miss budget is spent.
                if (miss_inc == MISS_LIM) begin
                  state  <= HUNT;
                  locked <= 1'b0;
                end else begin
                  state <= PAYLOAD;
                end
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_diff_frame_ctrl.sv
// Scoreboard bench for diff_frame_ctrl: the driver queues expected payload
// dibits, a negedge monitor pops and compares on every ab_valid.
module tb_diff_frame_ctrl;

  localparam logic [15:0] SYNC = 16'h1ACF;
  localparam int          FLEN = 64;
  localparam int          MISS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [1:0] cd = 2'b00;
  logic [1:0] ab;
  logic       ab_valid;
  logic       frame_start;
  logic       frame_end;
  logic       locked;
  logic       inv;

  always #5 clk = ~clk;

  diff_frame_ctrl #(
    .SYNC_WORD(SYNC),
    .FRAME_LEN(FLEN),
    .MISS_MAX (MISS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_valid  (sym_valid),
    .cd         (cd),
    .ab         (ab),
    .ab_valid   (ab_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .locked     (locked),
    .inv        (inv)
  );

  typedef struct packed {
    logic [1:0] ab;
    logic       fs;
    logic       fe;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         fs_cnt   = 0;
  int         fe_cnt   = 0;
  logic [1:0] cd_state = 2'b00;
  logic       last_valid = 1'b0;
  logic       mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one decoded dibit d, re-encoding it against the previously sent cd.
  task automatic send(input logic [1:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      sym_valid = 1'b0;
    end
    @(negedge clk);
    cd        = cd_state ^ d;
    cd_state  = cd;
    sym_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sym_valid = 1'b0;
    end
  endtask

  function automatic int gap_of(input bit gapped);
    return gapped ? int'($urandom_range(5, 0)) : 0;
  endfunction

  task automatic send_word(input logic [15:0] s, input bit gapped);
    for (int i = 7; i >= 0; i--) send(s[2*i +: 2], gap_of(gapped));
  endtask

  task automatic send_sync(input bit neg, input bit gapped);
    send_word(neg ? ~SYNC : SYNC, gapped);
  endtask

  // First dibit flipped 00 -> 01: matches neither polarity.
  task automatic send_bad_sync();
    send_word(SYNC ^ 16'h4000, 1'b0);
  endtask

  task automatic send_frame(input bit invx, input int seed, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      logic [1:0] d;
      exp_t       e;
      d    = 2'((i * 3 + i / 5 + seed) & 3);
      e.ab = d ^ {invx, invx};
      e.fs = (i == 0);
      e.fe = (i == FLEN - 1);
      exp_q.push_back(e);
      send(d, gap_of(gapped));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ab"}, ab, 0);
    check({tag, "_ab_valid"}, ab_valid, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_frame_end"}, frame_end, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_inv"}, inv, 0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst       = 1'b1;
    sym_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    cd_state = 2'b00;
    check_outputs_zero("after_rst");
  endtask

  always @(posedge clk) last_valid <= sym_valid && !rst;

  // NOTE: outputs are sampled on the falling edge, half a cycle clear of the
  // rising edge that updates them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ab_valid) begin
        check("ab_valid_after_valid", last_valid, 1);
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("ab", ab, mon_e.ab);
          check("frame_start", frame_start, mon_e.fs);
          check("frame_end", frame_end, mon_e.fe);
        end
        fs_cnt += frame_start;
        fe_cnt += frame_end;
      end else begin
        check("no_strobe_when_idle", {frame_start, frame_end}, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Clean lock followed by back-to-back frames.
    send_sync(1'b0, 1'b0);
    idle(1);
    check("clean_locked", locked, 1);
    check("clean_inv", inv, 0);
    send_frame(1'b0, 0, FLEN, 1'b0);
    send_sync(1'b0, 1'b0);
    send_frame(1'b0, 2, FLEN, 1'b0);
    send_sync(1'b0, 1'b0);
    send_frame(1'b0, 3, FLEN, 1'b0);
    idle(3);
    check("b2b_frame_starts", fs_cnt, 3);
    check("b2b_frame_ends", fe_cnt, 3);
    check("b2b_locked", locked, 1);
    check("b2b_drained", exp_q.size(), 0);

    // Inverted sync acquired from HUNT; first payload dibit 01 -> ab 10.
    pulse_rst();
    send_sync(1'b1, 1'b0);
    idle(1);
    check("inv_locked", locked, 1);
    check("inv_flag", inv, 1);
    send_frame(1'b1, 1, FLEN, 1'b0);

    // Re-sync in true polarity, then three corrupted sync words.
    send_sync(1'b0, 1'b0);
    idle(1);
    check("resync_inv_cleared", inv, 0);
    send_frame(1'b0, 4, FLEN, 1'b0);
    send_bad_sync();
    idle(1);
    check("flywheel1_locked", locked, 1);
    send_frame(1'b0, 5, FLEN, 1'b0);
    send_bad_sync();
    idle(1);
    check("flywheel2_locked", locked, 1);
    send_frame(1'b0, 6, FLEN, 1'b0);
    send_bad_sync();
    idle(1);
    check("loss_locked", locked, 0);
    for (int i = 0; i < 70; i++) send(2'b00, 0);
    idle(2);
    check("loss_drained", exp_q.size(), 0);
    check("loss_still_unlocked", locked, 0);
    send_sync(1'b0, 1'b0);
    idle(1);
    check("relock_after_loss", locked, 1);
    send_frame(1'b0, 7, FLEN, 1'b0);

    // Reset in the middle of a frame.
    send_sync(1'b0, 1'b0);
    send_frame(1'b0, 8, 30, 1'b0);
    fe_cnt = 0;
    pulse_rst();
    idle(2);
    check("midrst_no_frame_end", fe_cnt, 0);
    check("midrst_drained", exp_q.size(), 0);
    send_sync(1'b0, 1'b0);
    idle(1);
    check("midrst_relock", locked, 1);
    send_frame(1'b0, 9, FLEN, 1'b0);
    idle(2);
    check("midrst_one_frame_end", fe_cnt, 1);

    // Same payload as the first gapless frames, with 0-5 idle cycles between symbols.
    pulse_rst();
    send_sync(1'b0, 1'b1);
    send_frame(1'b0, 0, FLEN, 1'b1);
    send_sync(1'b0, 1'b1);
    send_frame(1'b0, 2, FLEN, 1'b1);
    idle(4);
    check("gapped_drained", exp_q.size(), 0);
    check("gapped_locked", locked, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
